// File: rtl/fruit_icon_overlay.sv
// Overlays an ICON_W x ICON_H ROM icon on an RGB565 stream at a frame-latched position, delaying the video by ROM_LATENCY+2 cycles.
// Define FRUIT_ICON_OVERLAY_COLORKEY_EN to make ROM pixels equal to KEY_COLOR transparent.
module fruit_icon_overlay #(
    parameter int ICON_W      = 64,
    parameter int ICON_H      = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    input  logic                  show,
    input  logic [11:0]           pos_x,
    input  logic [11:0]           pos_y,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  active
);
    localparam int PIPE_D = ROM_LATENCY + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2} state_t;

    state_t                  state_q;
    logic                    active_q;
    logic [11:0]             x0_q, y0_q;
    logic                    vs_q, de_q;
    logic [11:0]             x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d, col_q, col_d, rom_addr_q, rom_addr_d;
    logic                    line_hit_q, line_hit_d;
    logic [PIPE_D-1:0]       vs_pipe_q, hs_pipe_q, de_pipe_q, win_pipe_q;
    logic [DATA_WIDTH-1:0]   rgb_pipe_q [PIPE_D];
    logic                    vs_out_q, hs_out_q, de_out_q;
    logic [DATA_WIDTH-1:0]   rgb_out_q, rgb_out_d;
    logic                    fs_s, de_fall_s, in_win_s, use_rom_s;
    logic [12:0]             x_end_s, y_end_s;

    assign fs_s      = vs_in & ~vs_q;
    assign de_fall_s = de_q & ~de_in;
    assign x_end_s   = {1'b0, x0_q} + 13'(ICON_W);
    assign y_end_s   = {1'b0, y0_q} + 13'(ICON_H);

    // Frame-level state machine; position is latched on every frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            x0_q     <= 12'd0;
            y0_q     <= 12'd0;
        end else begin
            if (fs_s) begin
                x0_q <= pos_x;
                y0_q <= pos_y;
            end
            case (state_q)
                IDLE: begin
                    state_q  <= show ? ARMED : IDLE;
                    active_q <= 1'b0;
                end
                ARMED: begin
                    if (fs_s) begin
                        state_q  <= ACTIVE;
                        active_q <= 1'b1;
                    end else if (!show) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (fs_s && !show) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Position counters, window test, ROM addressing and output pixel selection
    always_comb begin
        x_cnt_d = de_in ? x_cnt_q + 12'd1 : 12'd0;
        if (fs_s) begin
            y_cnt_d = 12'd0;
        end else if (de_fall_s) begin
            y_cnt_d = y_cnt_q + 12'd1;
        end else begin
            y_cnt_d = y_cnt_q;
        end
        in_win_s = de_in & active_q
                 & ({1'b0, x_cnt_q} >= {1'b0, x0_q}) & ({1'b0, x_cnt_q} < x_end_s)
                 & ({1'b0, y_cnt_q} >= {1'b0, y0_q}) & ({1'b0, y_cnt_q} < y_end_s);
        col_d = de_in ? col_q + {{(ADDR_WIDTH-1){1'b0}}, in_win_s} : {ADDR_WIDTH{1'b0}};
        if (fs_s || de_fall_s) begin
            line_hit_d = 1'b0;
        end else begin
            line_hit_d = line_hit_q | in_win_s;
        end
        // fs takes priority so a coincident line end cannot advance the new frame's base
        if (fs_s) begin
            row_base_d = {ADDR_WIDTH{1'b0}};
        end else if (de_fall_s && line_hit_q) begin
            row_base_d = row_base_q + ADDR_WIDTH'(ICON_W);
        end else begin
            row_base_d = row_base_q;
        end
        rom_addr_d = in_win_s ? row_base_q + col_q : rom_addr_q;
`ifdef FRUIT_ICON_OVERLAY_COLORKEY_EN
        use_rom_s = win_pipe_q[PIPE_D-1] & (rom_rd_data != KEY_COLOR);
`else
        use_rom_s = win_pipe_q[PIPE_D-1];
`endif
        if (!de_pipe_q[PIPE_D-1]) begin
            rgb_out_d = {DATA_WIDTH{1'b0}};
        end else if (use_rom_s) begin
            rgb_out_d = rom_rd_data;
        end else begin
            rgb_out_d = rgb_pipe_q[PIPE_D-1];
        end
    end

`ifndef FRUIT_ICON_OVERLAY_COLORKEY_EN
    logic unused_key_s;
    assign unused_key_s = ^KEY_COLOR;
`endif

    // Datapath registers and the latency-matching delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            x_cnt_q    <= 12'd0;
            y_cnt_q    <= 12'd0;
            row_base_q <= {ADDR_WIDTH{1'b0}};
            col_q      <= {ADDR_WIDTH{1'b0}};
            line_hit_q <= 1'b0;
            rom_addr_q <= {ADDR_WIDTH{1'b0}};
            vs_pipe_q  <= {PIPE_D{1'b0}};
            hs_pipe_q  <= {PIPE_D{1'b0}};
            de_pipe_q  <= {PIPE_D{1'b0}};
            win_pipe_q <= {PIPE_D{1'b0}};
            for (int i = 0; i < PIPE_D; i++) begin
                rgb_pipe_q[i] <= {DATA_WIDTH{1'b0}};
            end
            vs_out_q   <= 1'b0;
            hs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            rgb_out_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            vs_q       <= vs_in;
            de_q       <= de_in;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            line_hit_q <= line_hit_d;
            rom_addr_q <= rom_addr_d;
            vs_pipe_q  <= {vs_pipe_q[PIPE_D-2:0], vs_in};
            hs_pipe_q  <= {hs_pipe_q[PIPE_D-2:0], hs_in};
            de_pipe_q  <= {de_pipe_q[PIPE_D-2:0], de_in};
            win_pipe_q <= {win_pipe_q[PIPE_D-2:0], in_win_s};
            rgb_pipe_q[0] <= rgb_in;
            for (int i = 1; i < PIPE_D; i++) begin
                rgb_pipe_q[i] <= rgb_pipe_q[i-1];
            end
            vs_out_q   <= vs_pipe_q[PIPE_D-1];
            hs_out_q   <= hs_pipe_q[PIPE_D-1];
            de_out_q   <= de_pipe_q[PIPE_D-1];
            rgb_out_q  <= rgb_out_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign vs_out   = vs_out_q;
    assign hs_out   = hs_out_q;
    assign de_out   = de_out_q;
    assign rgb_out  = rgb_out_q;
    assign active   = active_q;
endmodule
